// File: rtl/instr_store.sv
// rtl/instr_store.sv - per-node program memory with serial loader and zero-latency fetch port
module instr_store #(
  parameter int                 DEPTH    = 16,
  parameter int                 INSTR_W  = 18,
  parameter int                 AW       = 8,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_err,
  input  logic [AW-1:0]      Addr_instr,
  output logic [INSTR_W-1:0] instr,
  output logic               at_last,
  output logic               oor,
  output logic               hlt_en,
  output logic [AW:0]        prog_len
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

  state_t             r_state;
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_prog_len;
  logic               r_load_err;
  logic [INSTR_W-1:0] r_mem [DEPTH];

  logic               w_xfer;
  logic               w_run;
  logic               w_in_range;
  logic [AW:0]        w_addr;

  assign load_ready = (r_state == S_LOAD) && (r_wr_ptr < DEPTH_L);
  // load_start wins over a same-cycle transfer, so the word is never written
  assign w_xfer     = load_ready && load_valid && !load_start;
  assign load_err   = r_load_err;
  assign prog_len   = r_prog_len;
  assign hlt_en     = (r_state != S_RUN);

  always_ff @(posedge clk) begin
    if (w_xfer) r_mem[r_wr_ptr[PW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
      r_load_err <= 1'b0;
    end else if (load_start) begin
      r_state    <= S_LOAD;
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
      r_load_err <= 1'b0;
    end else if (w_xfer) begin
      r_wr_ptr <= r_wr_ptr + ONE;
      if (load_last) begin
        r_state    <= S_RUN;
        r_prog_len <= r_wr_ptr + ONE;
      end else if (r_wr_ptr == LAST_IDX) begin
        r_state    <= S_RUN;
        r_prog_len <= DEPTH_L;
        r_load_err <= 1'b1;
      end
    end
  end

  // prog_len never exceeds DEPTH, so the range check also keeps reads inside memory
  assign w_run      = (r_state == S_RUN);
  assign w_addr     = {1'b0, Addr_instr};
  assign w_in_range = (w_addr < r_prog_len);
  assign instr      = (w_run && w_in_range) ? r_mem[Addr_instr[PW-1:0]] : NOP_WORD;
  assign at_last    = w_run && (w_addr == r_prog_len - ONE);
  assign oor        = w_run && !w_in_range;

endmodule

// File: doc/instr_store.md
Name: instr_store

Overview:
- Per-node program memory. It is the responder on the instruction-fetch interface driven by the node's program counter.
- The program counter drives Addr_instr. This block returns the 18-bit instr word in the same cycle and reports whether the fetched word is the program's last instruction.
- A serial valid/ready loader writes the program. While no valid program is present, hlt_en freezes the core.

Parameters:
DEPTH, 16, number of instruction slots (max program length); legal range 1 to 256.
INSTR_W, 18, instruction word width.
AW, 8, width of Addr_instr.
NOP_WORD, 18'h0, word returned for empty or out-of-range addresses.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
load_start  in  1  one-cycle pulse: discard current program, enter LOAD.
load_valid  in  1  load_data valid.
load_data  in  INSTR_W  instruction word to store.
load_last  in  1  qualifies load_data as the final word.
load_ready  out  1  store can accept a word this cycle.
load_err  out  1  sticky: overflow without load_last; cleared by load_start.
Addr_instr  in  AW  fetch address from the program counter.
instr  out  INSTR_W  fetched instruction (combinational from Addr_instr).
at_last  out  1  Addr_instr == prog_len-1 in RUN; core selects wrap-to-0 jump.
oor  out  1  Addr_instr >= prog_len in RUN.
hlt_en  out  1  core stall; high in EMPTY and LOAD.
prog_len  out  AW+1  number of valid instructions.

Behaviour:
- Reset (async, rst_n low):
  - state=EMPTY, wr_ptr=0, prog_len=0.
  - load_ready=0, load_err=0, hlt_en=1, at_last=0, oor=0.
  - instr=NOP_WORD.
  - Memory contents are not reset.
- Reset mid-LOAD aborts the load. After reset the block is in EMPTY.

States:
- EMPTY:
  - load_start -> LOAD.
  - Load handshake signals are ignored.
- LOAD:
  - On entry: wr_ptr=0, load_err=0, prog_len=0.
  - load_ready=1 while wr_ptr<DEPTH.
  - Transfer occurs on a rising edge with load_valid & load_ready: mem[wr_ptr]<=load_data, wr_ptr<=wr_ptr+1.
  - A transfer with load_last=1 -> RUN, prog_len<=wr_ptr+1.
  - A transfer at wr_ptr==DEPTH-1 with load_last=0 -> RUN, prog_len<=DEPTH, load_err<=1.
  - load_start in LOAD restarts: wr_ptr=0, and any accepted words are discarded. Same-cycle load_valid is ignored.
- RUN:
  - hlt_en=0, load_ready=0.
  - load_start -> LOAD. hlt_en rises the following cycle, since it is decoded from the registered state.

Fetch path (combinational, zero latency):
- instr = mem[Addr_instr] when state==RUN and Addr_instr<prog_len; otherwise NOP_WORD.
- at_last and oor are valid only in RUN; 0 otherwise.
- Comparisons are unsigned at AW+1 bits.
- Addresses >= DEPTH never index memory; they produce oor=1 and NOP_WORD.

Load widths:
- load_data is stored unmodified.
- prog_len never exceeds DEPTH.

Simultaneous events and edge cases:
- load_start takes priority over any same-cycle transfer.
- load_last on a word that is refused (load_ready=0) has no effect.
- A single-word program gives prog_len=1. With Addr_instr=0: at_last=1, oor=0.

Test Plan:
- Reset with rst_n=0 asynchronously mid-cycle -> hlt_en=1, load_ready=0, instr=18'h0, prog_len=0 immediately, without waiting for a clock edge.
- load_start, then 3 words 18'h00011, 18'h00022, 18'h00033 (last on third), with valid toggled off for one cycle between words -> prog_len=3, hlt_en=0. Addr 0/1/2 give instr 11/22/33. Addr 2: at_last=1. Addr 3: oor=1, instr=0.
- Load 16 words with load_last never asserted -> after the 16th transfer: RUN, prog_len=16, load_err=1, load_ready=0. A 17th valid word is not accepted.
- Single-word program 18'h3FFFF -> Addr 0 gives instr=18'h3FFFF, at_last=1. Addr 255 gives oor=1.
- From RUN (prog_len=3), pulse load_start and send 2 words -> hlt_en=1 during LOAD. The new prog_len=2, and Addr 2 now gives oor=1. load_err is cleared by load_start.
- Assert rst_n=0 after 2 of 4 words are loaded -> state EMPTY, prog_len=0, hlt_en=1. A new load_start followed by 1 word gives prog_len=1.
